awmc_water_valve_driver: RTL
============================

# awmc_water_valve_driver

Actuator-side responder for the washing-machine controller's water interface. It takes the controller's fill request (`valve_req`) and drain request (`drain_req`) and drives the inlet and drain solenoids. It enforces mutual exclusion and a minimum off time between actuations, and tracks the drum water level from flow-meter pulses. It reports full and empty status back to the controller and latches a fault when expected flow does not arrive.

## Interface

Parameters:
- `LVL_W`, 4: width of the level counter.
- `FILL_MAX`, 12: level count that means full; must be ≤ 2^LVL_W − 1.
- `HOLD_MIN`, 2: cycles both solenoids stay off after any actuation ends (≥1).
- `TIMEOUT`, 8: cycles allowed in FILL or DRAIN without a relevant pulse before fault (≥2).

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `valve_req`, in, 1: controller request to open the inlet.
- `drain_req`, in, 1: controller request to open the drain.
- `flow_pulse`, in, 1: one-cycle pulse, one unit of water in.
- `drain_pulse`, in, 1: one-cycle pulse, one unit of water out.
- `fault_clr`, in, 1: clears a latched fault.
- `valve_sol`, out, 1: inlet solenoid drive.
- `drain_sol`, out, 1: drain solenoid drive.
- `level`, out, LVL_W: current water level count.
- `level_full`, out, 1: high when level == FILL_MAX.
- `level_empty`, out, 1: high when level == 0.
- `fault`, out, 1: latched flow fault.

## Operation

- States: OFF, FILL, DRAIN, HOLD, FAULT.
- Solenoid outputs are a Moore decode of the state:
  - `valve_sol` = (state == FILL).
  - `drain_sol` = (state == DRAIN).
  - `fault` = (state == FAULT).
  - `valve_sol` and `drain_sol` are never high together.
- OFF transitions:
  - `valve_req` & !`drain_req` & !`level_full` → FILL.
  - `drain_req` & !`valve_req` & !`level_empty` → DRAIN.
  - Both requests high, or neither → stay OFF.
- FILL:
  - `flow_pulse` increments level, saturating at FILL_MAX. `drain_pulse` is ignored.
  - Exit to HOLD on the edge where any of these holds: `valve_req`=0, `drain_req`=1, or the level becomes FILL_MAX.
- DRAIN:
  - `drain_pulse` decrements level, saturating at 0. `flow_pulse` is ignored.
  - Exit to HOLD on the edge where any of these holds: `drain_req`=0, `valve_req`=1, or the level becomes 0.
- Pulses arriving in OFF, HOLD or FAULT are ignored; level is unchanged.
- Timeout counter:
  - Cleared on entry to FILL/DRAIN and on each relevant pulse; increments otherwise.
  - When it reaches TIMEOUT with no pulse in that cycle → FAULT.
  - Timeout has priority over a request-drop exit in the same cycle.
  - A relevant pulse in the TIMEOUT-th cycle prevents the fault.
- HOLD: counts HOLD_MIN cycles, then → OFF. Requests are not examined during HOLD.
- FAULT:
  - Both solenoids off; level retained.
  - `fault_clr` → HOLD. Otherwise FAULT is sticky.
- `level_full` and `level_empty` are combinational compares of the level register.

## Timing

- Reset (asynchronous, immediate on `reset_n` low): state OFF, level 0, timeout counter 0, hold counter 0.
  - Outputs after reset: `valve_sol`=0, `drain_sol`=0, `fault`=0, `level_empty`=1, `level_full`=0.
- Request-to-solenoid latency: a request sampled at edge N in OFF gives the solenoid high after edge N.
- Level-to-off latency: a pulse sampled at edge N that makes the level reach the limit also drops the solenoid after edge N, with zero extra cycles.
- Request-drop latency: the solenoid falls after the first edge that samples the drop.
- Minimum gap between any solenoid falling and any solenoid rising is HOLD_MIN+1 cycles: HOLD_MIN cycles in HOLD plus the OFF decision cycle.
- Fault assertion: `fault` rises TIMEOUT cycles after the last pulse, or after entry if no pulse arrived.
- Fault clear: `fault` falls one cycle after `fault_clr` is sampled.
- Reset asserted mid-FILL or mid-DRAIN: the solenoid drops immediately and level returns to 0. No HOLD is entered after release.

## Test plan

- Fill to full:
  - Stimulus: reset, `valve_req`=1, `flow_pulse` every 2nd cycle (FILL_MAX=12).
  - Response: `valve_sol` rises 1 cycle after the request; level steps to 12; `valve_sol` falls on the 12th pulse edge with `level_full`=1.
  - After 2 HOLD cycles the block is in OFF and stays off with `valve_req` still high.
- Drain to empty:
  - Stimulus: from level 12, `drain_req`=1, `drain_pulse` every cycle.
  - Response: `drain_sol` high; level counts 12→0; `drain_sol` falls on the edge where level reaches 0; `level_empty`=1.
- Request conflict:
  - Stimulus: in OFF, `valve_req` and `drain_req` both high for 20 cycles.
  - Response: both solenoids remain 0 and level is unchanged.
- Direction switch:
  - Stimulus: at level 5 in FILL, drop `valve_req` and raise `drain_req` on the same cycle.
  - Response: `valve_sol` falls, both solenoids stay 0 for 3 cycles, then `drain_sol` rises. The solenoids never overlap.
- Timeout and clear:
  - Stimulus: `valve_req`=1 with no pulses (TIMEOUT=8).
  - Response: `fault`=1 and `valve_sol`=0 8 cycles after entering FILL.
  - Stimulus: pulse `fault_clr`.
  - Response: `fault`=0 after 1 cycle, then HOLD 2 cycles, then FILL re-entered with level retained.
- Reset mid-drain:
  - Stimulus: drop `reset_n` asynchronously at level 7 during DRAIN.
  - Response: `drain_sol`=0 and level=0 without waiting for a clock edge; `level_empty`=1.

Source files
------------

// File: rtl/awmc_water_valve_driver.sv
// Water valve driver: interlocked inlet/drain solenoids, flow-pulse level tracking, no-flow fault latch.
// Solenoids follow the request one edge after sampling; no backpressure, pulses outside FILL/DRAIN are dropped.
module awmc_water_valve_driver #(
  parameter int LVL_W    = 4,
  parameter int FILL_MAX = 12,
  parameter int HOLD_MIN = 2,
  parameter int TIMEOUT  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valve_req,
  input  logic             drain_req,
  input  logic             flow_pulse,
  input  logic             drain_pulse,
  input  logic             fault_clr,
  output logic             valve_sol,
  output logic             drain_sol,
  output logic [LVL_W-1:0] level,
  output logic             level_full,
  output logic             level_empty,
  output logic             fault
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = (HOLD_MIN < 1) ? 1 : $clog2(HOLD_MIN + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FILL_MAX);

  typedef enum logic [2:0] {OFF, FILL, DRAIN, HOLD, FAULT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic [TW-1:0]    tcnt;
  logic [HW-1:0]    hcnt;
  logic             fill_pulse;
  logic             empty_pulse;
  logic             tmo_hit;

  assign fill_pulse  = (state == FILL) && flow_pulse;
  assign empty_pulse = (state == DRAIN) && drain_pulse;
  assign level_full  = (level == LVL_FULL);
  assign level_empty = (level == '0);
  assign tmo_hit     = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    level_nxt = level;
    if (fill_pulse && !level_full)
      level_nxt = level + LVL_W'(1);
    else if (empty_pulse && !level_empty)
      level_nxt = level - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= OFF;
    else
      state <= state_nxt;
  end

  // Timeout is checked before the normal exits so a silent meter always latches a fault.
  always_comb begin
    state_nxt = state;
    case (state)
      OFF: begin
        if (valve_req && !drain_req && !level_full)
          state_nxt = FILL;
        else if (drain_req && !valve_req && !level_empty)
          state_nxt = DRAIN;
      end
      FILL: begin
        if (!flow_pulse && tmo_hit)
          state_nxt = FAULT;
        else if (!valve_req || drain_req || (level_nxt == LVL_FULL))
          state_nxt = HOLD;
      end
      DRAIN: begin
        if (!drain_pulse && tmo_hit)
          state_nxt = FAULT;
        else if (!drain_req || valve_req || (level_nxt == '0))
          state_nxt = HOLD;
      end
      HOLD: begin
        if (hcnt == HW'(HOLD_MIN - 1))
          state_nxt = OFF;
      end
      FAULT: begin
        if (fault_clr)
          state_nxt = HOLD;
      end
      default: state_nxt = OFF;
    endcase
  end

  always_comb begin
    valve_sol = (state == FILL);
    drain_sol = (state == DRAIN);
    fault     = (state == FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      tcnt  <= '0;
      hcnt  <= '0;
    end else begin
      level <= level_nxt;
      // Counts only while staying in the same actuation with no relevant pulse; entry or pulse restarts it.
      if ((state == FILL && state_nxt == FILL && !flow_pulse) ||
          (state == DRAIN && state_nxt == DRAIN && !drain_pulse))
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      if (state == HOLD)
        hcnt <= hcnt + HW'(1);
      else
        hcnt <= '0;
    end
  end

endmodule
